// File: rtl/vga_sprite_engine.sv
// VGA raster timing generator with NUM_SPRITES fixed-priority rectangle sprites.
// Sprite state is shadowed once per frame so CPU writes never tear the picture.
module vga_sprite_engine #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [16*NUM_SPRITES-1:0] sprite_x,
    input  logic [16*NUM_SPRITES-1:0] sprite_y,
    input  logic [NUM_SPRITES-1:0]    sprite_en,
    input  logic [24*NUM_SPRITES-1:0] sprite_rgb,
    input  logic [23:0]               bg_rgb,
    output logic                      clk_25MHz,
    output logic                      h_sync,
    output logic                      v_sync,
    output logic                      sync_n,
    output logic                      blank_n,
    output logic [7:0]                red_out,
    output logic [7:0]                green_out,
    output logic [7:0]                blue_out,
    output logic                      frame_start,
    output logic [9:0]                hcount,
    output logic [9:0]                vcount
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] V_LATCH  = 10'(V_VIS - 1);

    logic                      clk25_q, clk25_d;
    logic [9:0]                hcount_q, hcount_d;
    logic [9:0]                vcount_q, vcount_d;
    logic                      hs_q, hs_d;
    logic                      vs_q, vs_d;
    logic                      blank_n_q, blank_n_d;
    logic [23:0]               rgb_q, rgb_d;
    logic                      frame_start_q, frame_start_d;
    logic [16*NUM_SPRITES-1:0] sx_q, sx_d;
    logic [16*NUM_SPRITES-1:0] sy_q, sy_d;
    logic [NUM_SPRITES-1:0]    sen_q, sen_d;
    logic [24*NUM_SPRITES-1:0] srgb_q, srgb_d;

    logic                      pix_tick;
    logic                      hs_raw;
    logic                      vs_raw;
    logic                      vis;
    logic                      latch;
    logic [NUM_SPRITES-1:0]    hit;
    logic [23:0]               pix_rgb;
    logic [16:0]               h_ext;
    logic [16:0]               v_ext;

    assign pix_tick = clk25_q;
    assign hs_raw   = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
    assign vs_raw   = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
    assign vis      = (hcount_q < H_VIS_C) && (vcount_q < V_VIS_C);
    assign latch    = pix_tick && (hcount_q == H_LAST) && (vcount_q == V_LATCH);
    assign h_ext    = {7'b0, hcount_q};
    assign v_ext    = {7'b0, vcount_q};

    // 17-bit bounds so a sprite near 0xFFFF cannot wrap round onto column/row 0
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        logic [16:0] x_lo;
        logic [16:0] y_lo;
        assign x_lo   = {1'b0, sx_q[16*g +: 16]};
        assign y_lo   = {1'b0, sy_q[16*g +: 16]};
        assign hit[g] = sen_q[g]
                        && (h_ext >= x_lo) && (h_ext < x_lo + 17'(SPRITE_W))
                        && (v_ext >= y_lo) && (v_ext < y_lo + 17'(SPRITE_H));
    end

    // Walk from the highest index down so the lowest hitting sprite is written last
    always_comb begin
        pix_rgb = bg_rgb;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pix_rgb = srgb_q[24*i +: 24];
            end
        end
        if (!vis) begin
            pix_rgb = 24'h0;
        end
    end

    always_comb begin
        clk25_d       = ~clk25_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        blank_n_d     = blank_n_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;
        sx_d          = sx_q;
        sy_d          = sy_q;
        sen_d         = sen_q;
        srgb_d        = srgb_q;

        if (pix_tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
            hs_d      = hs_raw;
            vs_d      = vs_raw;
            blank_n_d = vis;
            rgb_d     = pix_rgb;
            // Last tick before vertical blanking: take a fresh snapshot for the next frame
            if (latch) begin
                sx_d          = sprite_x;
                sy_d          = sprite_y;
                sen_d         = sprite_en;
                srgb_d        = sprite_rgb;
                frame_start_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk25_q       <= 1'b0;
            hcount_q      <= 10'd0;
            vcount_q      <= 10'd0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            rgb_q         <= 24'h0;
            frame_start_q <= 1'b0;
            sx_q          <= '0;
            sy_q          <= '0;
            sen_q         <= '0;
            srgb_q        <= '0;
        end else begin
            clk25_q       <= clk25_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            sen_q         <= sen_d;
            srgb_q        <= srgb_d;
        end
    end

    assign clk_25MHz   = clk25_q;
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign sync_n      = 1'b0;
    assign blank_n     = blank_n_q;
    assign red_out     = rgb_q[23:16];
    assign green_out   = rgb_q[15:8];
    assign blue_out    = rgb_q[7:0];
    assign frame_start = frame_start_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Self-checking bench for vga_sprite_engine using a reduced raster so whole frames stay short.
// A pixel-index reference model checks every pin each clock; table and hand sequences probe specific pixels.
module tb_vga_sprite_engine;

    localparam int N   = 4;
    localparam int SW  = 8;
    localparam int SH  = 6;
    localparam int HV  = 32;
    localparam int HFP = 4;
    localparam int HSY = 6;
    localparam int HBP = 4;
    localparam int VV  = 24;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int HT  = HV + HFP + HSY + HBP;
    localparam int VT  = VV + VFP + VSY + VBP;
    localparam int FRAME_CLK = 2 * HT * VT;
    localparam int WAIT_LIMIT = 2 * FRAME_CLK + 100;
    localparam logic [23:0] BG = 24'h123456;

    typedef struct packed {
        logic [16*N-1:0] xs;
        logic [16*N-1:0] ys;
        logic [N-1:0]    en;
        logic [24*N-1:0] rgbs;
    } cfg_t;

    typedef struct {
        cfg_t        cfg;
        int          ph;
        int          pv;
        logic [23:0] exp_rgb;
        logic        exp_blank;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [16*N-1:0] sprite_x;
    logic [16*N-1:0] sprite_y;
    logic [N-1:0]    sprite_en;
    logic [24*N-1:0] sprite_rgb;
    logic [23:0]     bg_rgb;
    logic            clk_25MHz, h_sync, v_sync, sync_n, blank_n, frame_start;
    logic [7:0]      red_out, green_out, blue_out;
    logic [9:0]      hcount, vcount;

    int total = 0;
    int bad   = 0;
    bit sb_on = 0;

    vga_sprite_engine #(
        .NUM_SPRITES(N), .SPRITE_W(SW), .SPRITE_H(SH),
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
        .sprite_rgb(sprite_rgb), .bg_rgb(bg_rgb),
        .clk_25MHz(clk_25MHz), .h_sync(h_sync), .v_sync(v_sync), .sync_n(sync_n),
        .blank_n(blank_n), .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .frame_start(frame_start), .hcount(hcount), .vcount(vcount)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the raster is a pixel index counted from reset release
    int          k;
    int          p, h, v;
    logic [15:0] m_sx [N];
    logic [15:0] m_sy [N];
    logic        m_en [N];
    logic [23:0] m_rgb [N];
    logic        e_clk, e_hs, e_vs, e_blank, e_fs;
    logic [23:0] e_rgb;
    int          e_h, e_v;

    function automatic logic [23:0] expectedColour(input int ph, input int pv);
        if (!(ph < HV && pv < VV)) return 24'h0;
        for (int i = 0; i < N; i++) begin
            if (m_en[i] && ph >= int'(m_sx[i]) && ph < int'(m_sx[i]) + SW
                        && pv >= int'(m_sy[i]) && pv < int'(m_sy[i]) + SH)
                return m_rgb[i];
        end
        return bg_rgb;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            k = 0;
            for (int i = 0; i < N; i++) begin
                m_sx[i] = 16'h0; m_sy[i] = 16'h0; m_en[i] = 1'b0; m_rgb[i] = 24'h0;
            end
            e_clk = 0; e_hs = 1; e_vs = 1; e_blank = 0; e_rgb = 24'h0; e_fs = 0;
            e_h = 0; e_v = 0;
        end else begin
            k++;
            e_fs = 0;
            if (k % 2 == 0) begin
                p = k / 2 - 1;
                h = p % HT;
                v = (p / HT) % VT;
                e_hs    = !(h >= HV + HFP && h < HV + HFP + HSY);
                e_vs    = !(v >= VV + VFP && v < VV + VFP + VSY);
                e_blank = (h < HV && v < VV);
                e_rgb   = expectedColour(h, v);
                if (h == HT - 1 && v == VV - 1) begin
                    for (int i = 0; i < N; i++) begin
                        m_sx[i]  = sprite_x[16*i +: 16];
                        m_sy[i]  = sprite_y[16*i +: 16];
                        m_en[i]  = sprite_en[i];
                        m_rgb[i] = sprite_rgb[24*i +: 24];
                    end
                    e_fs = 1;
                end
            end
            e_clk = logic'(k % 2);
            e_h   = (k / 2) % HT;
            e_v   = (k / 2 / HT) % VT;
        end
    end

    always @(negedge clk) begin
        if (sb_on) begin
            checkOutput("scoreboard pins",
                {14'h0, clk_25MHz, h_sync, v_sync, sync_n, blank_n, red_out, green_out, blue_out,
                 frame_start, hcount, vcount},
                {14'h0, e_clk, e_hs, e_vs, 1'b0, e_blank, e_rgb, e_fs, 10'(e_h), 10'(e_v)});
        end
    end

    task automatic applyStimulus(input cfg_t c);
        @(negedge clk);
        sprite_x   = c.xs;
        sprite_y   = c.ys;
        sprite_en  = c.en;
        sprite_rgb = c.rgbs;
    endtask

    function automatic cfg_t withSprite(input cfg_t c, input int i, input logic [15:0] x,
                                        input logic [15:0] y, input logic [23:0] rgb, input logic en);
        cfg_t r = c;
        r.xs[16*i +: 16]   = x;
        r.ys[16*i +: 16]   = y;
        r.rgbs[24*i +: 24] = rgb;
        r.en[i]            = en;
        return r;
    endfunction

    task automatic waitFrameStart(input string name);
        bit found = 0;
        for (int n = 0; n < WAIT_LIMIT && !found; n++) begin
            @(negedge clk);
            if (frame_start) found = 1;
        end
        if (!found) checkOutput({name, " frame_start timeout"}, 64'd0, 64'd1);
    endtask

    task automatic waitLine(input int line, input string name);
        bit found = 0;
        for (int n = 0; n < WAIT_LIMIT && !found; n++) begin
            @(negedge clk);
            if (int'(vcount) == line) found = 1;
        end
        if (!found) checkOutput({name, " vcount timeout"}, 64'd0, 64'd1);
    endtask

    task automatic probePixel(input int ph, input int pv, input logic [23:0] er,
                              input logic eb, input string name);
        bit found = 0;
        for (int n = 0; n < WAIT_LIMIT && !found; n++) begin
            @(negedge clk);
            if (int'(hcount) == ph && int'(vcount) == pv && !clk_25MHz) found = 1;
        end
        if (!found) begin
            checkOutput({name, " position timeout"}, 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            checkOutput({name, " rgb"}, {40'h0, red_out, green_out, blue_out}, {40'h0, er});
            checkOutput({name, " blank_n"}, {63'h0, blank_n}, {63'h0, eb});
        end
    endtask

    vec_t vecs[$];
    cfg_t c0, ca, cb, cc, cd, ce, cm;

    initial begin
        int   n;
        bit   found;
        cfg_t prev;

        reset = 1'b0;
        sprite_x = '0; sprite_y = '0; sprite_en = '0; sprite_rgb = '0;
        bg_rgb = BG;

        c0 = '0;
        ca = withSprite(withSprite(c0, 0, 16'd10, 16'd5, 24'hFF0000, 1'b1),
                        1, 16'd14, 16'd5, 24'h00FF00, 1'b1);
        cb = withSprite(c0, 0, 16'd28, 16'd20, 24'h0F0F0F, 1'b1);
        cc = withSprite(c0, 0, 16'hFFFC, 16'd5, 24'hFFFFFF, 1'b1);
        cd = withSprite(withSprite(c0, 2, 16'd22, 16'd15, 24'hABCDEF, 1'b1),
                        3, 16'd20, 16'd15, 24'h0000FF, 1'b1);
        ce = withSprite(c0, 0, 16'd10, 16'd5, 24'hFF0000, 1'b0);
        cm = withSprite(c0, 0, 16'd4, 16'd12, 24'hFF00FF, 1'b1);

        vecs.push_back('{ca, 14,  5, 24'hFF0000, 1'b1});
        vecs.push_back('{ca, 18,  5, 24'h00FF00, 1'b1});
        vecs.push_back('{ca, 22,  5, BG,         1'b1});
        vecs.push_back('{ca, 10, 10, 24'hFF0000, 1'b1});
        vecs.push_back('{ca, 10, 11, BG,         1'b1});
        vecs.push_back('{cb, 31, 23, 24'h0F0F0F, 1'b1});
        vecs.push_back('{cb,  0, 21, BG,         1'b1});
        vecs.push_back('{cb, 32, 20, 24'h000000, 1'b0});
        vecs.push_back('{cc,  2,  5, BG,         1'b1});
        vecs.push_back('{cd, 22, 15, 24'hABCDEF, 1'b1});
        vecs.push_back('{cd, 21, 15, 24'h0000FF, 1'b1});
        vecs.push_back('{ce, 10,  5, BG,         1'b1});

        // Reset held for three clocks
        @(posedge clk);
        sb_on = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset clk_25MHz", {63'h0, clk_25MHz}, 64'd0);
        checkOutput("reset h_sync", {63'h0, h_sync}, 64'd1);
        checkOutput("reset v_sync", {63'h0, v_sync}, 64'd1);
        checkOutput("reset blank_n", {63'h0, blank_n}, 64'd0);
        checkOutput("reset rgb", {40'h0, red_out, green_out, blue_out}, 64'd0);
        checkOutput("reset frame_start", {63'h0, frame_start}, 64'd0);
        checkOutput("reset hcount", {54'h0, hcount}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("hcount after release", {54'h0, hcount}, 64'd1);

        // h_sync lag and width
        found = 0;
        for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
            @(negedge clk);
            if (int'(hcount) == HV + HFP && !clk_25MHz) found = 1;
        end
        checkOutput("hsync start seen", {63'h0, found}, 64'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (h_sync && n < 10);
        checkOutput("hsync lag clk", 64'(n), 64'd2);
        n = 1;
        while (n < 4 * HT) begin
            @(negedge clk);
            if (h_sync) break;
            n++;
        end
        checkOutput("hsync width clk", 64'(n), 64'(2 * HSY));

        // Line period
        found = 0;
        for (int i = 0; i < 4 * HT && !found; i++) begin
            @(negedge clk);
            if (hcount == 10'd0 && !clk_25MHz) found = 1;
        end
        n = 0;
        found = 0;
        for (int i = 0; i < 4 * HT && !found; i++) begin
            @(negedge clk);
            n++;
            if (hcount == 10'd0 && !clk_25MHz) found = 1;
        end
        checkOutput("line period clk", 64'(n), 64'(2 * HT));

        // One frame_start per frame
        n = 0;
        for (int i = 0; i < FRAME_CLK; i++) begin
            @(negedge clk);
            if (frame_start) n++;
        end
        checkOutput("frame_start per frame", 64'(n), 64'd1);

        // Table of sprite configurations and probe pixels
        prev = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].cfg != prev) begin
                applyStimulus(vecs[i].cfg);
                waitFrameStart($sformatf("vec%0d", i));
                prev = vecs[i].cfg;
            end
            probePixel(vecs[i].ph, vecs[i].pv, vecs[i].exp_rgb, vecs[i].exp_blank,
                       $sformatf("vec%0d", i));
        end

        // Mid-frame position change must wait for the next latch
        applyStimulus(cm);
        waitFrameStart("midframe");
        waitLine(8, "midframe");
        sprite_x[15:0] = 16'd20;
        probePixel(4, 12, 24'hFF00FF, 1'b1, "midframe old pos");
        probePixel(20, 12, BG, 1'b1, "midframe new pos early");
        waitFrameStart("midframe next");
        probePixel(4, 12, BG, 1'b1, "midframe old pos after latch");
        probePixel(20, 12, 24'hFF00FF, 1'b1, "midframe new pos after latch");

        // Reset in the middle of a frame
        waitLine(15, "midreset");
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset hcount", {54'h0, hcount}, 64'd0);
        checkOutput("midreset vcount", {54'h0, vcount}, 64'd0);
        checkOutput("midreset syncs", {62'h0, h_sync, v_sync}, 64'd3);
        checkOutput("midreset blank_rgb", {39'h0, blank_n, red_out, green_out, blue_out}, 64'd0);
        checkOutput("midreset clk_25MHz", {63'h0, clk_25MHz}, 64'd0);
        reset = 1'b1;
        probePixel(20, 12, BG, 1'b1, "post reset sprite hidden");
        waitFrameStart("post reset");
        probePixel(20, 12, 24'hFF00FF, 1'b1, "post reset sprite shown");

        // Random register traffic, checked by the reference model
        for (int i = 0; i < 2 * FRAME_CLK + 200; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) begin
                for (int s = 0; s < N; s++) begin
                    if ($urandom_range(0, 7) == 0)
                        sprite_x[16*s +: 16] = 16'($urandom_range(16'hFFF0, 16'hFFFF));
                    else
                        sprite_x[16*s +: 16] = 16'($urandom_range(0, HV + 8));
                    sprite_y[16*s +: 16]   = 16'($urandom_range(0, VV + 6));
                    sprite_rgb[24*s +: 24] = 24'($urandom);
                end
                sprite_en = N'($urandom);
                bg_rgb    = 24'($urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
